cache_nway: RTL and testbench
=============================

CACHE_NWAY -- requirements
Module: cache_nway

Interface
REQ-001 SHALL have parameter WAYS, default 2, associativity; power of two, 2..8.
REQ-002 SHALL have parameter SETS, default 8, number of sets; power of two, 2..64.
REQ-003 SHALL have parameter LINE_BITS, default 128, line width in bits; power of two, 32..256.
REQ-004 Derived widths SHALL be: OFF = log2(LINE_BITS/8), IDX = log2(SETS), TAG = 16-IDX-OFF. The address fields SHALL be tag = [15:IDX+OFF], index = [IDX+OFF-1:OFF], offset = [OFF-1:0].
REQ-005 clk  in  1  sole clock; all state changes on rising edge.
REQ-006 rst_n  in  1  reset; asynchronous assert, active-low.
REQ-007 mem_address  in  16  CPU byte address.
REQ-008 mem_read / mem_write  in  1 each  CPU request strobes; held until mem_resp.
REQ-009 mem_wdata  in  16  CPU write word.
REQ-010 mem_byte_enable  in  2  byte mask for writes.
REQ-011 mem_rdata  out  16  read word; mem_resp  out  1  one-cycle completion pulse.
REQ-012 pmem_address  out  16  line-aligned address (offset bits zero).
REQ-013 pmem_read / pmem_write  out  1 each  memory strobes; pmem_rdata in / pmem_wdata out  LINE_BITS  line data; pmem_resp  in  1  memory completion.

Function
REQ-014 Per set, SHALL store WAYS x {valid, dirty, tag[TAG], data[LINE_BITS]} plus WAYS-1 tree pseudo-LRU bits. Array reads SHALL be combinational.
REQ-015 A hit SHALL be defined as: any way is valid and its tag equals the address tag. At most one way SHALL hit.
REQ-016 The FSM SHALL have states IDLE, WRITEBACK, FILL. The reset state SHALL be IDLE.
REQ-017 IDLE, request and hit: mem_resp SHALL be asserted in the same cycle (zero-wait). mem_rdata SHALL be the 16-bit word at offset[OFF-1:1] of the hit line.
REQ-018 On a write hit, the masked bytes of the addressed word SHALL be merged into the line at the clock edge, and dirty SHALL be set for that way.
REQ-019 Every hit, and every completed fill, SHALL update the PLRU bits to point away from the accessed way.
REQ-020 IDLE, request and miss: the victim SHALL be the lowest-numbered invalid way if one exists, otherwise the PLRU way. The victim SHALL be latched for the whole miss.
REQ-021 If the victim is valid and dirty, the FSM SHALL go to WRITEBACK. Otherwise it SHALL go to FILL.
REQ-022 WRITEBACK SHALL behave as follows: pmem_write=1; pmem_address = {victim tag, index, 0}; pmem_wdata = victim line. On pmem_resp the FSM SHALL go to FILL.
REQ-023 FILL SHALL behave as follows: pmem_read=1; pmem_address = {request tag, index, 0}. On pmem_resp it SHALL write the line, set the tag, set valid=1 and dirty=0, and return to IDLE.
REQ-024 After a fill the request SHALL be re-evaluated in IDLE and complete as a hit one cycle later. Writes are write-allocate.
REQ-025 mem_read and mem_write both high SHALL be treated as a write.
REQ-026 pmem_read and pmem_write SHALL never be high together. mem_resp SHALL be 0 outside IDLE.
REQ-027 Behaviour if the CPU changes its request before mem_resp is undefined. The bench SHALL not do this.

Reset
REQ-028 While rst_n=0: all valid, dirty and PLRU bits SHALL be 0; state SHALL be IDLE; mem_resp, pmem_read and pmem_write SHALL be 0.
REQ-029 Tag and data arrays SHALL not be reset.
REQ-030 Reset asserted during WRITEBACK or FILL SHALL abort the transaction immediately. The memory strobes SHALL drop in the same cycle.

Configuration
REQ-031 Macro CACHE_PERF_COUNT_EN SHALL control the performance counters.
REQ-032 With CACHE_PERF_COUNT_EN defined, the block SHALL add outputs hit_count[31:0] and miss_count[31:0].
REQ-033 hit_count SHALL increment once per mem_resp that had no preceding miss. miss_count SHALL increment once per IDLE to WRITEBACK or IDLE to FILL transition.
REQ-034 Both counters SHALL wrap modulo 2^32 and SHALL be cleared by rst_n.
REQ-035 Without CACHE_PERF_COUNT_EN, the counter ports and logic SHALL be absent. Behaviour SHALL otherwise be identical.

Verification
REQ-036 Cold miss: after reset, read 0x1234 -> pmem_read with pmem_address=0x1230, no pmem_write. Return a line with word 2 = 0xBEEF -> mem_resp one cycle after the fill with mem_rdata=0xBEEF.
REQ-037 Write hit with byte mask: write 0x1234, wdata=0xAA55, mask=01 -> mem_resp in the same cycle. A following read of 0x1234 returns 0xBE55.
REQ-038 Dirty eviction, WAYS=2: fill three tags into one index with the first line dirty -> third miss issues pmem_write of the PLRU victim line at its old address, then pmem_read.
REQ-039 Invalid-way preference, WAYS=4: fill way 0, then miss on a new tag -> way 1 is filled and way 0 is retained, confirmed by re-reading its address as a zero-wait hit.
REQ-040 Reset mid-FILL: drop rst_n while pmem_read=1 -> pmem_read=0 in the same cycle. After release, a read of the same address misses again.
REQ-041 Counters, with CACHE_PERF_COUNT_EN defined: run 3 misses and 5 hits -> miss_count=3, hit_count=5.

Source files
------------

// File: rtl/cache_nway.sv
// cache_nway: WAYS-way set-associative write-back, write-allocate cache with
// tree pseudo-LRU replacement. Hits complete in the same cycle. Misses fetch
// the line from pmem and then replay the request as a hit.
// Define CACHE_PERF_COUNT_EN to add the hit_count / miss_count outputs.
module cache_nway #(
  parameter int unsigned WAYS      = 2,
  parameter int unsigned SETS      = 8,
  parameter int unsigned LINE_BITS = 128
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [15:0]          mem_address,
  input  logic                 mem_read,
  input  logic                 mem_write,
  input  logic [15:0]          mem_wdata,
  input  logic [1:0]           mem_byte_enable,
  output logic [15:0]          mem_rdata,
  output logic                 mem_resp,
  output logic [15:0]          pmem_address,
  output logic                 pmem_read,
  output logic                 pmem_write,
  input  logic [LINE_BITS-1:0] pmem_rdata,
  output logic [LINE_BITS-1:0] pmem_wdata,
  input  logic                 pmem_resp
`ifdef CACHE_PERF_COUNT_EN
  ,
  output logic [31:0]          hit_count,
  output logic [31:0]          miss_count
`endif
);

  localparam int unsigned OFF   = $clog2(LINE_BITS / 8);
  localparam int unsigned IDX   = $clog2(SETS);
  localparam int unsigned TAG   = 16 - IDX - OFF;
  localparam int unsigned WW    = $clog2(WAYS);
  localparam int unsigned WSEL  = OFF - 1;
  localparam int unsigned NODES = WAYS - 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WB   = 2'd1;
  localparam logic [1:0] S_FILL = 2'd2;

  logic [WAYS-1:0]      r_valid [SETS];
  logic [WAYS-1:0]      r_dirty [SETS];
  logic [NODES-1:0]     r_plru  [SETS];
  logic [TAG-1:0]       r_tag   [SETS][WAYS];
  logic [LINE_BITS-1:0] r_data  [SETS][WAYS];
  logic [1:0]           r_state;
  logic [WW-1:0]        r_victim;

  logic [1:0]           w_next_state;
  logic [TAG-1:0]       w_tag;
  logic [IDX-1:0]       w_idx;
  logic [WSEL-1:0]      w_word;
  logic                 w_unused_bit;
  logic                 w_req;
  logic                 w_hit;
  logic [WW-1:0]        w_hit_way;
  logic [WW-1:0]        w_plru_way;
  logic [WW-1:0]        w_victim;
  logic [WW-1:0]        w_upd_way;
  logic [NODES-1:0]     w_plru_new;
  logic [LINE_BITS-1:0] w_hit_line;
  logic [LINE_BITS-1:0] w_wr_line;
  logic                 w_idle_hit;
  logic                 w_idle_miss;
  logic                 w_fill_done;

  assign w_tag        = mem_address[15 -: TAG];
  assign w_idx        = mem_address[OFF +: IDX];
  assign w_word       = mem_address[1 +: WSEL];
  assign w_unused_bit = mem_address[0];
  assign w_req        = mem_read | mem_write;

  // Tag compare across all ways of the addressed set
  always_comb begin
    w_hit     = 1'b0;
    w_hit_way = '0;
    for (int w = 0; w < int'(WAYS); w++) begin
      if (r_valid[w_idx][w] && (r_tag[w_idx][w] == w_tag)) begin
        w_hit     = 1'b1;
        w_hit_way = WW'(w);
      end
    end
  end

  // Victim: lowest invalid way, else the way the PLRU tree points at
  always_comb begin
    int  node;
    logic b;
    node = 0;
    for (int l = 0; l < int'(WW); l++) begin
      b = 1'b0;
      for (int n = 0; n < int'(NODES); n++) begin
        if (n == node) b = r_plru[w_idx][n];
      end
      node = 2 * node + 1 + int'(b);
    end
    w_plru_way = WW'(node - int'(NODES));
    w_victim   = w_plru_way;
    for (int w = int'(WAYS) - 1; w >= 0; w--) begin
      if (!r_valid[w_idx][w]) w_victim = WW'(w);
    end
  end

  // PLRU tree update: each node on the path points away from the accessed way
  assign w_upd_way = (r_state == S_FILL) ? r_victim : w_hit_way;
  always_comb begin
    int node;
    int d;
    w_plru_new = r_plru[w_idx];
    node       = 0;
    for (int l = 0; l < int'(WW); l++) begin
      d = (int'(w_upd_way) >> (int'(WW) - 1 - l)) & 1;
      for (int n = 0; n < int'(NODES); n++) begin
        if (n == node) w_plru_new[n] = (d == 0);
      end
      node = 2 * node + 1 + d;
    end
  end

  // Hit-line word read and byte-masked write merge
  assign w_hit_line = r_data[w_idx][w_hit_way];
  assign mem_rdata  = w_hit_line[{w_word, 4'd0} +: 16];
  always_comb begin
    w_wr_line = w_hit_line;
    if (mem_byte_enable[0]) w_wr_line[{w_word, 4'd0} +: 8] = mem_wdata[7:0];
    if (mem_byte_enable[1]) w_wr_line[{w_word, 4'd8} +: 8] = mem_wdata[15:8];
  end

  assign w_idle_hit  = (r_state == S_IDLE) && w_req && w_hit;
  assign w_idle_miss = (r_state == S_IDLE) && w_req && !w_hit;
  assign w_fill_done = (r_state == S_FILL) && pmem_resp;
  assign pmem_wdata  = r_data[w_idx][r_victim];

  // Next state and strobes, decoded from the registered state
  always_comb begin
    w_next_state = r_state;
    mem_resp     = 1'b0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = {w_tag, w_idx, {OFF{1'b0}}};
    case (r_state)
      S_IDLE: begin
        mem_resp = w_req && w_hit;
        if (w_idle_miss) begin
          w_next_state = (r_valid[w_idx][w_victim] && r_dirty[w_idx][w_victim]) ? S_WB : S_FILL;
        end
      end
      S_WB: begin
        pmem_write   = 1'b1;
        pmem_address = {r_tag[w_idx][r_victim], w_idx, {OFF{1'b0}}};
        if (pmem_resp) w_next_state = S_FILL;
      end
      S_FILL: begin
        pmem_read = 1'b1;
        if (pmem_resp) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // State, victim latch and per-way status bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_victim <= '0;
      for (int s = 0; s < int'(SETS); s++) begin
        r_valid[s] <= '0;
        r_dirty[s] <= '0;
        r_plru[s]  <= '0;
      end
    end else begin
      r_state <= w_next_state;
      if (w_idle_miss) r_victim <= w_victim;
      if (w_idle_hit) begin
        r_plru[w_idx] <= w_plru_new;
        if (mem_write) r_dirty[w_idx][w_hit_way] <= 1'b1;
      end
      if (w_fill_done) begin
        r_plru[w_idx]            <= w_plru_new;
        r_valid[w_idx][r_victim] <= 1'b1;
        r_dirty[w_idx][r_victim] <= 1'b0;
      end
    end
  end

  // Tag and data arrays: line fill from pmem, or write-hit merge
  always_ff @(posedge clk) begin
    if (w_fill_done) begin
      r_data[w_idx][r_victim] <= pmem_rdata;
      r_tag[w_idx][r_victim]  <= w_tag;
    end else if (w_idle_hit && mem_write) begin
      r_data[w_idx][w_hit_way] <= w_wr_line;
    end
  end

`ifdef CACHE_PERF_COUNT_EN
  logic r_missed;

  // Hits count only responses that were not preceded by a miss
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_count  <= '0;
      miss_count <= '0;
      r_missed   <= 1'b0;
    end else begin
      if (w_idle_miss) begin
        miss_count <= miss_count + 32'd1;
        r_missed   <= 1'b1;
      end
      if (mem_resp) begin
        r_missed <= 1'b0;
        if (!r_missed) hit_count <= hit_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_cache_nway.sv
// tb_cache_nway: scoreboard bench for cache_nway. Instance a is 2-way, instance
// b is 4-way; sel routes the CPU port and the memory model to one of them.
module tb_cache_nway;

  localparam int unsigned LB = 128;

  typedef struct {
    logic        chk;
    logic [15:0] rdata;
    logic        hit;
    int          start;
    string       name;
  } resp_t;

  typedef struct {
    logic [1:0]    rw;
    logic [15:0]   addr;
    logic          chk;
    logic [LB-1:0] wdata;
    string         name;
  } pm_t;

  logic          clk;
  logic          rst_n;
  logic          sel;
  logic [15:0]   mem_address;
  logic          mem_read;
  logic          mem_write;
  logic [15:0]   mem_wdata;
  logic [1:0]    mem_byte_enable;
  logic [LB-1:0] pmem_rdata;
  logic          pmem_resp;

  logic          a_rd, a_wr, a_presp, a_resp, a_pr, a_pw;
  logic          b_rd, b_wr, b_presp, b_resp, b_pr, b_pw;
  logic [15:0]   a_rdata, a_paddr, b_rdata, b_paddr;
  logic [LB-1:0] a_pwd, b_pwd;
  logic          s_resp, s_pr, s_pw, s_presp;
  logic [15:0]   s_rdata, s_paddr;
  logic [LB-1:0] s_pwd;
`ifdef CACHE_PERF_COUNT_EN
  logic [31:0]   a_hits, a_miss, b_hits_unused, b_miss_unused;
`endif

  resp_t         rq[$];
  pm_t           pq[$];
  logic [LB-1:0] mem [logic [15:0]];
  int            cyc, last_presp, mem_cnt, n_pass, n_total;

  assign a_rd    = mem_read  & ~sel;
  assign a_wr    = mem_write & ~sel;
  assign a_presp = pmem_resp & ~sel;
  assign b_rd    = mem_read  &  sel;
  assign b_wr    = mem_write &  sel;
  assign b_presp = pmem_resp &  sel;
  assign s_resp  = sel ? b_resp  : a_resp;
  assign s_rdata = sel ? b_rdata : a_rdata;
  assign s_pr    = sel ? b_pr    : a_pr;
  assign s_pw    = sel ? b_pw    : a_pw;
  assign s_paddr = sel ? b_paddr : a_paddr;
  assign s_pwd   = sel ? b_pwd   : a_pwd;
  assign s_presp = pmem_resp;

  cache_nway u_a (
    .clk(clk), .rst_n(rst_n), .mem_address(mem_address), .mem_read(a_rd),
    .mem_write(a_wr), .mem_wdata(mem_wdata), .mem_byte_enable(mem_byte_enable),
    .mem_rdata(a_rdata), .mem_resp(a_resp), .pmem_address(a_paddr),
    .pmem_read(a_pr), .pmem_write(a_pw), .pmem_rdata(pmem_rdata),
    .pmem_wdata(a_pwd), .pmem_resp(a_presp)
`ifdef CACHE_PERF_COUNT_EN
    , .hit_count(a_hits), .miss_count(a_miss)
`endif
  );

  cache_nway #(.WAYS(4)) u_b (
    .clk(clk), .rst_n(rst_n), .mem_address(mem_address), .mem_read(b_rd),
    .mem_write(b_wr), .mem_wdata(mem_wdata), .mem_byte_enable(mem_byte_enable),
    .mem_rdata(b_rdata), .mem_resp(b_resp), .pmem_address(b_paddr),
    .pmem_read(b_pr), .pmem_write(b_pw), .pmem_rdata(pmem_rdata),
    .pmem_wdata(b_pwd), .pmem_resp(b_presp)
`ifdef CACHE_PERF_COUNT_EN
    , .hit_count(b_hits_unused), .miss_count(b_miss_unused)
`endif
  );

  // Default backing line: word k of the line at address a holds a+k
  function automatic logic [LB-1:0] pat(input logic [15:0] a);
    logic [LB-1:0] l;
    for (int k = 0; k < 8; k++) l[k*16 +: 16] = a + 16'(k);
    return l;
  endfunction

  function automatic logic [LB-1:0] line_of(input logic [15:0] a);
    if (mem.exists(a)) return mem[a];
    return pat(a);
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, got, exp);
  endtask

  task automatic exp_pmem(input logic [1:0] rw, input logic [15:0] a, input logic c,
                          input logic [LB-1:0] wd, input string nm);
    pm_t p;
    p.rw = rw; p.addr = a; p.chk = c; p.wdata = wd; p.name = nm;
    pq.push_back(p);
  endtask

  // Issue one CPU request, hold it until mem_resp, then release it
  task automatic cpu(input logic wr, input logic [15:0] a, input logic [15:0] wd,
                     input logic [1:0] be, input logic c, input logic [15:0] exp_rd,
                     input logic hit, input string nm);
    resp_t e;
    logic  done;
    e.chk = c; e.rdata = exp_rd; e.hit = hit; e.start = cyc; e.name = nm;
    rq.push_back(e);
    mem_address = a; mem_wdata = wd; mem_byte_enable = be;
    mem_write = wr; mem_read = !wr;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (s_resp) done = 1'b1;
    end
    if (!done) begin
      n_total++;
      $display("FAIL %s_timeout: no mem_resp within 40 cycles", nm);
      if (rq.size() > 0) void'(rq.pop_front());
    end
    @(posedge clk); #1;
    mem_read = 1'b0; mem_write = 1'b0;
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Memory model: answers each strobe after two cycles with a one-cycle pmem_resp
  initial begin : pmem_model
    pmem_resp = 1'b0; pmem_rdata = '0; mem_cnt = 0;
    forever begin
      @(posedge clk); #1;
      if (pmem_resp) begin
        pmem_resp = 1'b0; mem_cnt = 0;
      end else if (rst_n && (s_pr || s_pw)) begin
        mem_cnt++;
        if (mem_cnt == 2) begin
          if (s_pw) mem[s_paddr] = s_pwd;
          else pmem_rdata = line_of(s_paddr);
          pmem_resp = 1'b1;
        end
      end else begin
        mem_cnt = 0;
      end
    end
  end

  // Monitor: pops the scoreboards on every mem_resp and every new pmem transaction
  initial begin : monitor
    logic [1:0] prev;
    logic [1:0] cur;
    logic       ok;
    resp_t      e;
    pm_t        p;
    prev = 2'b00;
    forever begin
      @(negedge clk);
      if (s_resp) begin
        n_total++;
        if (rq.size() == 0) begin
          $display("FAIL unexpected_resp: mem_resp with nothing pending, rdata=%h", s_rdata);
        end else begin
          e  = rq.pop_front();
          ok = e.hit ? (cyc == e.start) : (last_presp > e.start && cyc == last_presp + 1);
          if (e.chk && s_rdata !== e.rdata) ok = 1'b0;
          if (ok) n_pass++;
          else $display("FAIL %s: rdata=%h latency=%0d, want rdata=%h hit=%0d",
                        e.name, s_rdata, cyc - e.start, e.rdata, e.hit);
        end
      end
      if (s_presp) last_presp = cyc;
      cur = {s_pr, s_pw};
      if (cur != 2'b00 && cur != prev) begin
        n_total++;
        if (pq.size() == 0) begin
          $display("FAIL unexpected_pmem: rd/wr=%b addr=%h", cur, s_paddr);
        end else begin
          p  = pq.pop_front();
          ok = (cur == p.rw) && (s_paddr == p.addr) && (!p.chk || s_pwd == p.wdata);
          if (ok) n_pass++;
          else $display("FAIL %s: rd/wr=%b addr=%h wdata=%h, want rd/wr=%b addr=%h wdata=%h",
                        p.name, cur, s_paddr, s_pwd, p.rw, p.addr, p.wdata);
        end
      end
      prev = cur;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    logic [LB-1:0] l;
    logic          seen;
    n_pass = 0; n_total = 0; last_presp = -1;
    sel = 1'b0; rst_n = 1'b0;
    mem_address = 16'h1234; mem_read = 1'b1; mem_write = 1'b0;
    mem_wdata = '0; mem_byte_enable = '0;
    l = pat(16'h1230); l[47:32] = 16'hBEEF; mem[16'h1230] = l;

    // Reset holds everything idle even with a request applied
    repeat (2) @(negedge clk);
    chk("rst_mem_resp", 32'(s_resp), 32'd0);
    chk("rst_pmem_read", 32'(s_pr), 32'd0);
    chk("rst_pmem_write", 32'(s_pw), 32'd0);
    @(posedge clk); #1;
    mem_read = 1'b0; rst_n = 1'b1;

    // Cold miss, then byte-masked write hit and readback
    exp_pmem(2'b10, 16'h1230, 1'b0, '0, "cold_fill");
    cpu(1'b0, 16'h1234, 16'h0, 2'b00, 1'b1, 16'hBEEF, 1'b0, "cold_read");
    cpu(1'b1, 16'h1234, 16'hAA55, 2'b01, 1'b0, 16'h0, 1'b1, "wr_hit");
    cpu(1'b0, 16'h1234, 16'h0, 2'b00, 1'b1, 16'hBE55, 1'b1, "rd_merge");

    // Dirty eviction on the third tag in set 3
    exp_pmem(2'b10, 16'h12B0, 1'b0, '0, "fill_way1");
    cpu(1'b0, 16'h12B0, 16'h0, 2'b00, 1'b1, 16'h12B0, 1'b0, "read_way1");
    l = pat(16'h1230); l[47:32] = 16'hBE55;
    exp_pmem(2'b01, 16'h1230, 1'b1, l, "evict_wb");
    exp_pmem(2'b10, 16'h1330, 1'b0, '0, "evict_fill");
    cpu(1'b0, 16'h1330, 16'h0, 2'b00, 1'b1, 16'h1330, 1'b0, "evict_read");
    exp_pmem(2'b10, 16'h1230, 1'b0, '0, "refetch_fill");
    cpu(1'b0, 16'h1234, 16'h0, 2'b00, 1'b1, 16'hBE55, 1'b0, "refetch_read");

    // Reset in the middle of a fill drops the strobe at once
    exp_pmem(2'b10, 16'h4440, 1'b0, '0, "abort_fill");
    mem_address = 16'h4440; mem_read = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (s_pr) seen = 1'b1;
    end
    chk("abort_fill_seen", 32'(seen), 32'd1);
    #1; rst_n = 1'b0; mem_read = 1'b0;
    #1;
    chk("abort_pmem_read", 32'(s_pr), 32'd0);
    chk("abort_pmem_write", 32'(s_pw), 32'd0);
    repeat (2) @(posedge clk);
    #1; rst_n = 1'b1;

    // Three misses then five hits from a freshly reset cache
    exp_pmem(2'b10, 16'h4440, 1'b0, '0, "post_rst_fill");
    cpu(1'b0, 16'h4440, 16'h0, 2'b00, 1'b1, 16'h4440, 1'b0, "post_rst_miss");
    exp_pmem(2'b10, 16'h1230, 1'b0, '0, "cnt_fill1");
    cpu(1'b0, 16'h1234, 16'h0, 2'b00, 1'b1, 16'hBE55, 1'b0, "cnt_miss1");
    exp_pmem(2'b10, 16'h12B0, 1'b0, '0, "cnt_fill2");
    cpu(1'b0, 16'h12B0, 16'h0, 2'b00, 1'b1, 16'h12B0, 1'b0, "cnt_miss2");
    cpu(1'b0, 16'h4440, 16'h0, 2'b00, 1'b1, 16'h4440, 1'b1, "cnt_hit1");
    cpu(1'b0, 16'h1234, 16'h0, 2'b00, 1'b1, 16'hBE55, 1'b1, "cnt_hit2");
    cpu(1'b0, 16'h12B2, 16'h0, 2'b00, 1'b1, 16'h12B1, 1'b1, "cnt_hit3");
    cpu(1'b1, 16'h12B2, 16'h1111, 2'b11, 1'b0, 16'h0, 1'b1, "cnt_hit4_wr");
    cpu(1'b0, 16'h12B2, 16'h0, 2'b00, 1'b1, 16'h1111, 1'b1, "cnt_hit5");
`ifdef CACHE_PERF_COUNT_EN
    chk("miss_count", a_miss, 32'd3);
    chk("hit_count", a_hits, 32'd5);
`endif

    // 4-way: second miss fills the invalid way 1 and keeps way 0
    sel = 1'b1;
    exp_pmem(2'b10, 16'h1230, 1'b0, '0, "w4_fill0");
    cpu(1'b0, 16'h1234, 16'h0, 2'b00, 1'b1, 16'hBE55, 1'b0, "w4_read0");
    exp_pmem(2'b10, 16'h12B0, 1'b0, '0, "w4_fill1");
    cpu(1'b0, 16'h12B0, 16'h0, 2'b00, 1'b1, 16'h12B0, 1'b0, "w4_read1");
    cpu(1'b0, 16'h1234, 16'h0, 2'b00, 1'b1, 16'hBE55, 1'b1, "w4_way0_kept");
    cpu(1'b0, 16'h12B0, 16'h0, 2'b00, 1'b1, 16'h12B0, 1'b1, "w4_way1_kept");

    repeat (3) @(posedge clk);
    chk("resp_queue_empty", 32'(rq.size()), 32'd0);
    chk("pmem_queue_empty", 32'(pq.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
